// File: rtl/change_dispenser.sv
// change_dispenser: payout side of the vending machine.
// Accepts a change amount in cents and drives the coin ejector one coin at a
// time over a valid/ack handshake. Coins are chosen greedily (largest first)
// from per-denomination inventories. Any unpayable residue is reported.
//
// Optional build macro: CHANGE_TIMEOUT_EN adds an ack watchdog that aborts
// the transaction with jam=1 after TIMEOUT_CYCLES cycles without eject_ack.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   start, amount    request payout of amount (cents), sampled in IDLE only
//   refill           reload every inventory to INV_INIT, IDLE only
//   eject_ack        ejector accepted the presented coin
//   eject_valid      coin request presented
//   eject_coin       0 none, 1 nickel, 2 dime, 3 quarter, 4 fifty, 5 dollar
//   busy             state is not IDLE
//   done             one-cycle pulse at transaction end
//   short_flag       last transaction left an unpaid residue
//   shortfall        unpaid residue in cents
//   jam              ack timeout abort (0 unless CHANGE_TIMEOUT_EN)
module change_dispenser #(
  parameter int unsigned INV_INIT       = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] amount,
  input  logic       refill,
  input  logic       eject_ack,
  output logic       eject_valid,
  output logic [2:0] eject_coin,
  output logic       busy,
  output logic       done,
  output logic       short_flag,
  output logic [8:0] shortfall,
  output logic       jam
);

  localparam int unsigned AmtW   = 9;
  localparam int unsigned InvW   = 8;
  localparam int unsigned CoinW  = 3;
  localparam int unsigned NumDen = 5;
  localparam logic [InvW-1:0] InvInit = InvW'(INV_INIT);

  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} stateT;

  stateT            state, stateNext;
  logic [AmtW-1:0]  remaining, remainingNext;
  logic [InvW-1:0]  inv [NumDen];
  logic [InvW-1:0]  invNext [NumDen];
  logic             validNext, busyNext, doneNext, shortFlagNext;
  logic [CoinW-1:0] coinNext, pick, coinIdx;
  logic [AmtW-1:0]  shortfallNext;
  logic             found;

  // Coin code to value in cents; code 0 is "no coin".
  function automatic logic [AmtW-1:0] coinValue(input logic [CoinW-1:0] code);
    case (code)
      3'd1:    coinValue = 9'd5;
      3'd2:    coinValue = 9'd10;
      3'd3:    coinValue = 9'd25;
      3'd4:    coinValue = 9'd50;
      3'd5:    coinValue = 9'd100;
      default: coinValue = 9'd0;
    endcase
  endfunction

  // Inventory slot of the coin being presented (code 1 -> slot 0).
  assign coinIdx = CoinW'(eject_coin - 3'd1);

`ifdef CHANGE_TIMEOUT_EN
  localparam int unsigned TimerW = 16;
  logic [TimerW-1:0] timer, timerNext;
  logic              jamNext;
`else
  assign jam = 1'b0;
  // Parameter only meaningful with the watchdog; keep it referenced.
  if (TIMEOUT_CYCLES == 0) begin : gNoTimeout
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    invNext       = inv;
    validNext     = eject_valid;
    coinNext      = eject_coin;
    shortFlagNext = short_flag;
    shortfallNext = shortfall;
    found         = 1'b0;
    pick          = '0;
`ifdef CHANGE_TIMEOUT_EN
    jamNext       = jam;
    timerNext     = '0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          remainingNext = amount;
          shortFlagNext = 1'b0;
          shortfallNext = '0;
`ifdef CHANGE_TIMEOUT_EN
          jamNext       = 1'b0;
`endif
          stateNext     = SELECT;
        end else if (refill) begin
          for (int i = 0; i < NumDen; i++) invNext[i] = InvInit;
        end
      end
      SELECT: begin
        // Largest denomination that fits and is still stocked.
        for (int i = NumDen - 1; i >= 0; i--) begin
          if (!found && inv[i] != '0 && coinValue(CoinW'(i + 1)) <= remaining) begin
            found = 1'b1;
            pick  = CoinW'(i + 1);
          end
        end
        if (remaining == '0) begin
          stateNext = DONE;
        end else if (found) begin
          coinNext  = pick;
          validNext = 1'b1;
          stateNext = EJECT;
        end else begin
          shortFlagNext = 1'b1;
          shortfallNext = remaining;
          stateNext     = DONE;
        end
      end
      EJECT: begin
        if (eject_ack) begin
          remainingNext    = remaining - coinValue(eject_coin);
          invNext[coinIdx] = inv[coinIdx] - 8'd1;
          validNext        = 1'b0;
          coinNext         = '0;
          stateNext        = SELECT;
`ifdef CHANGE_TIMEOUT_EN
        end else if (timer == TimerW'(TIMEOUT_CYCLES - 1)) begin
          // Abort without deducting the pending coin.
          validNext     = 1'b0;
          coinNext      = '0;
          jamNext       = 1'b1;
          shortFlagNext = 1'b1;
          shortfallNext = remaining;
          stateNext     = DONE;
        end else begin
          timerNext = timer + 16'd1;
`endif
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    doneNext = (stateNext == DONE);
    busyNext = (stateNext != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      eject_valid <= 1'b0;
      eject_coin  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      short_flag  <= 1'b0;
      shortfall   <= '0;
      for (int i = 0; i < NumDen; i++) inv[i] <= InvInit;
`ifdef CHANGE_TIMEOUT_EN
      jam         <= 1'b0;
      timer       <= '0;
`endif
    end else begin
      state       <= stateNext;
      remaining   <= remainingNext;
      eject_valid <= validNext;
      eject_coin  <= coinNext;
      busy        <= busyNext;
      done        <= doneNext;
      short_flag  <= shortFlagNext;
      shortfall   <= shortfallNext;
      for (int i = 0; i < NumDen; i++) inv[i] <= invNext[i];
`ifdef CHANGE_TIMEOUT_EN
      jam         <= jamNext;
      timer       <= timerNext;
`endif
    end
  end

endmodule
